// File: rtl/dvp_rgb565_capture.sv
// dvp_rgb565_capture
//   Front-end capture for the DVP video path. Packs the 8-bit CMOS bus
//   (RGB565, high byte first) into 24-bit RGB888 pixels. Output stays
//   muted until FRAME_SKIP vsync rising edges have been seen. Line and
//   frame geometry are checked against IMG_HDISP / IMG_VDISP.
//
//   Ports
//     clk          CMOS pixel clock (byte rate)
//     rst_n        asynchronous active-low reset
//     cmos_vsync   sensor vsync, high between frames
//     cmos_href    sensor line valid
//     cmos_data    sensor byte
//     post_vs      frame sync, aligned with post_de/post_data
//     post_de      one-cycle pixel strobe
//     post_data    {R8,G8,B8}, holds between strobes
//     frame_valid  high once the skip count is reached
//     line_err     one-cycle pulse after a line of wrong length
//     frame_err    one-cycle pulse at vsync after a frame of wrong height
//
//   Byte-phase FSM
//     state  | meaning
//     PH_HI  | next byte on data_d is the high byte of a pixel
//     PH_LO  | next byte on data_d completes the pixel
module dvp_rgb565_capture #(
  parameter logic [11:0] IMG_HDISP  = 12'd1280,
  parameter logic [11:0] IMG_VDISP  = 12'd720,
  parameter logic [7:0]  FRAME_SKIP = 8'd10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic        post_vs,
  output logic        post_de,
  output logic [23:0] post_data,
  output logic        frame_valid,
  output logic        line_err,
  output logic        frame_err
);

  typedef enum logic {
    PH_HI = 1'b0,
    PH_LO = 1'b1
  } phase_t;

  phase_t      phase, phase_next;

  logic        vs_d, href_d;
  logic [7:0]  data_d;
  logic        vs_d2, href_d2;
  logic [7:0]  hi_byte;
  logic [11:0] x_cnt, y_cnt;
  logic [7:0]  skip_cnt;
  logic        armed;

  logic        latch_hi, pix_strobe, odd_bytes;
  logic        vs_rise, href_fall, pix_out;
  logic [15:0] pix565;
  logic [23:0] pix888;
  logic [11:0] y_line;
  logic [7:0]  skip_next;

  // ---------------- byte-phase FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= PH_HI;
    else        phase <= phase_next;
  end

  always_comb begin
    phase_next = PH_HI;
    if (href_d) phase_next = (phase == PH_HI) ? PH_LO : PH_HI;
  end

  // While href_d is low the phase still reflects the parity of the byte
  // count of the line that just ended, which is what odd_bytes reports.
  always_comb begin
    latch_hi   = 1'b0;
    pix_strobe = 1'b0;
    odd_bytes  = 1'b0;
    if (href_d) begin
      latch_hi   = (phase == PH_HI);
      pix_strobe = (phase == PH_LO);
    end else begin
      odd_bytes  = (phase == PH_LO);
    end
  end

  // ---------------- datapath ----------------
  assign vs_rise   = vs_d & ~vs_d2;
  assign href_fall = href_d2 & ~href_d;
  assign pix565    = {hi_byte, data_d};
  assign pix888    = {pix565[15:11], pix565[15:13],
                      pix565[10:5],  pix565[10:9],
                      pix565[4:0],   pix565[4:2]};

  // armed is cleared by reset and set by the first vsync rise, so a reset
  // in mid-frame never releases the tail of a partially seen frame.
  assign pix_out   = pix_strobe & frame_valid & armed;

  // Line count including a line ending in this same cycle, so a vsync
  // rise coinciding with an href fall still sees the final line.
  assign y_line    = (href_fall && (y_cnt != 12'hFFF)) ? y_cnt + 12'd1 : y_cnt;

  assign skip_next = (vs_rise && (skip_cnt < FRAME_SKIP)) ? skip_cnt + 8'd1 : skip_cnt;

  assign post_vs   = vs_d2 & frame_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d        <= 1'b0;
      href_d      <= 1'b0;
      data_d      <= 8'd0;
      vs_d2       <= 1'b0;
      href_d2     <= 1'b0;
      hi_byte     <= 8'd0;
      x_cnt       <= 12'd0;
      y_cnt       <= 12'd0;
      skip_cnt    <= 8'd0;
      armed       <= 1'b0;
      frame_valid <= 1'b0;
      post_de     <= 1'b0;
      post_data   <= 24'd0;
      line_err    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      vs_d    <= cmos_vsync;
      href_d  <= cmos_href;
      data_d  <= cmos_data;
      vs_d2   <= vs_d;
      href_d2 <= href_d;

      if (latch_hi) hi_byte <= data_d;

      if (href_fall)                             x_cnt <= 12'd0;
      else if (pix_strobe && (x_cnt != 12'hFFF)) x_cnt <= x_cnt + 12'd1;

      line_err <= href_fall & ((x_cnt != IMG_HDISP) | odd_bytes);

      if (vs_rise) y_cnt <= 12'd0;
      else         y_cnt <= y_line;

      frame_err <= vs_rise & armed & (y_line != IMG_VDISP);

      if (vs_rise) armed <= 1'b1;

      skip_cnt    <= skip_next;
      frame_valid <= (skip_next == FRAME_SKIP);

      post_de <= pix_out;
      if (pix_out) post_data <= pix888;
    end
  end

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
module tb_dvp_rgb565_capture;

  localparam logic [11:0] HD = 12'd4;
  localparam logic [11:0] VD = 12'd2;
  localparam int SKIP_A = 2;
  localparam int SKIP_B = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmos_vsync = 1'b0;
  logic       cmos_href = 1'b0;
  logic [7:0] cmos_data = 8'd0;

  logic        post_vs_a, post_de_a, frame_valid_a, line_err_a, frame_err_a;
  logic [23:0] post_data_a;
  logic        post_vs_b, post_de_b, frame_valid_b, line_err_b, frame_err_b;
  logic [23:0] post_data_b;

  always #5 clk = ~clk;

  dvp_rgb565_capture #(.IMG_HDISP(HD), .IMG_VDISP(VD), .FRAME_SKIP(8'(SKIP_A))) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .post_vs(post_vs_a), .post_de(post_de_a),
    .post_data(post_data_a), .frame_valid(frame_valid_a), .line_err(line_err_a),
    .frame_err(frame_err_a));

  dvp_rgb565_capture #(.IMG_HDISP(HD), .IMG_VDISP(VD), .FRAME_SKIP(8'(SKIP_B))) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cmos_vsync(cmos_vsync), .cmos_href(cmos_href),
    .cmos_data(cmos_data), .post_vs(post_vs_b), .post_de(post_de_b),
    .post_data(post_data_b), .frame_valid(frame_valid_b), .line_err(line_err_b),
    .frame_err(frame_err_b));

  typedef struct packed {
    logic [23:0] data;
    logic [31:0] t;
  } pix_t;

  pix_t q_a[$];
  pix_t q_b[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  int vs_since_rst = 0;
  int lines_in_frame = 0;
  int exp_lerr = 0, exp_ferr = 0;
  int got_lerr_a = 0, got_lerr_b = 0, got_ferr_a = 0, got_ferr_b = 0;
  logic [7:0] fixed_bytes [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // RGB565 -> RGB888 by scaling each channel: top bits shifted up, the
  // low bits refilled with the channel's own most significant bits.
  function automatic logic [23:0] rgb888(input logic [15:0] p);
    int r, g, b;
    r = (int'(p) >> 11) & 31;
    g = (int'(p) >> 5) & 63;
    b = int'(p) & 31;
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return 24'(r * 65536 + g * 256 + b);
  endfunction

  function automatic bit enabled(input int skip);
    return vs_since_rst >= ((skip > 0) ? skip : 1);
  endfunction

  // Pin history: what the sensor pins looked like at recent clock edges,
  // and how many vsync rises had been seen one edge ago.
  logic s0, s1;
  int   rises, rises_d, since;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0 <= 1'b0; s1 <= 1'b0; rises <= 0; rises_d <= 0; since <= 0;
    end else begin
      s0 <= cmos_vsync;
      s1 <= s0;
      if (cmos_vsync && !s0) rises <= rises + 1;
      rises_d <= rises;
      if (since < 1000) since <= since + 1;
    end
  end

  function automatic logic fv_exp(input int skip);
    return (since >= 1) && (rises_d >= skip);
  endfunction

  // Monitor: pops the scoreboard on every strobe and tracks sync/valid.
  always @(negedge clk) begin
    pix_t p;
    if (mon_en) begin
      if (post_de_a) begin
        if (q_a.size() == 0) chk("unexpected_de_a", 32'd1, 32'd0);
        else begin
          p = q_a.pop_front();
          chk("pix_data_a", 32'(post_data_a), 32'(p.data));
          chk("pix_time_a", 32'(cyc), p.t);
        end
      end
      if (post_de_b) begin
        if (q_b.size() == 0) chk("unexpected_de_b", 32'd1, 32'd0);
        else begin
          p = q_b.pop_front();
          chk("pix_data_b", 32'(post_data_b), 32'(p.data));
          chk("pix_time_b", 32'(cyc), p.t);
        end
      end
      chk("frame_valid_a", 32'(frame_valid_a), 32'(fv_exp(SKIP_A)));
      chk("frame_valid_b", 32'(frame_valid_b), 32'(fv_exp(SKIP_B)));
      chk("post_vs_a", 32'(post_vs_a), 32'(s1 & fv_exp(SKIP_A)));
      chk("post_vs_b", 32'(post_vs_b), 32'(s1 & fv_exp(SKIP_B)));
      if (line_err_a)  got_lerr_a++;
      if (line_err_b)  got_lerr_b++;
      if (frame_err_a) got_ferr_a++;
      if (frame_err_b) got_ferr_b++;
    end
  end

  task automatic drive(input logic h, input logic v, input logic [7:0] d);
    @(posedge clk);
    #1;
    cmos_href  = h;
    cmos_vsync = v;
    cmos_data  = d;
  endtask

  task automatic gap(input int k);
    repeat (k) drive(1'b0, 1'b0, 8'd0);
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_line_err_a"},  32'(got_lerr_a), 32'(exp_lerr));
    chk({tag, "_line_err_b"},  32'(got_lerr_b), 32'(exp_lerr));
    chk({tag, "_frame_err_a"}, 32'(got_ferr_a), 32'(exp_ferr));
    chk({tag, "_frame_err_b"}, 32'(got_ferr_b), 32'(exp_ferr));
  endtask

  // Bytes of a line with href high; href is lowered by end_line.
  task automatic send_line(input int n, input bit fixed);
    logic [7:0] b, hi;
    hi = 8'd0;
    for (int i = 0; i < n; i++) begin
      b = fixed ? fixed_bytes[i] : 8'($urandom_range(0, 255));
      drive(1'b1, 1'b0, b);
      if (i % 2 == 0) hi = b;
      else begin
        if (enabled(SKIP_A)) q_a.push_back('{data: rgb888({hi, b}), t: 32'(cyc + 2)});
        if (enabled(SKIP_B)) q_b.push_back('{data: rgb888({hi, b}), t: 32'(cyc + 2)});
      end
    end
  endtask

  task automatic end_line(input logic vs, input int n);
    drive(1'b0, vs, 8'd0);
    lines_in_frame++;
    if ((n / 2 != int'(HD)) || (n % 2 != 0)) exp_lerr++;
  endtask

  task automatic line(input int n, input bit fixed);
    send_line(n, fixed);
    end_line(1'b0, n);
    gap(3);
    check_counts("line");
  endtask

  task automatic vsync(input bit already_high);
    if (vs_since_rst > 0 && lines_in_frame != int'(VD)) exp_ferr++;
    lines_in_frame = 0;
    vs_since_rst++;
    repeat (already_high ? 2 : 3) drive(1'b0, 1'b1, 8'd0);
    gap(4);
    check_counts("vsync");
    chk("pending_a", 32'(q_a.size()), 32'd0);
    chk("pending_b", 32'(q_b.size()), 32'd0);
  endtask

  task automatic do_reset(input int n_low);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    q_a.delete();
    q_b.delete();
    repeat (n_low) begin
      @(posedge clk);
      #1;
      chk("reset_outs_a", 32'({post_vs_a, post_de_a, post_data_a, frame_valid_a, line_err_a, frame_err_a}), 32'd0);
      chk("reset_outs_b", 32'({post_vs_b, post_de_b, post_data_b, frame_valid_b, line_err_b, frame_err_b}), 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    vs_since_rst = 0;
    lines_in_frame = 0;
  endtask

  initial begin
    fixed_bytes[0] = 8'hF8; fixed_bytes[1] = 8'h00;
    fixed_bytes[2] = 8'h07; fixed_bytes[3] = 8'hE0;
    fixed_bytes[4] = 8'h00; fixed_bytes[5] = 8'h1F;
    fixed_bytes[6] = 8'hFF; fixed_bytes[7] = 8'hFF;

    do_reset(4);
    mon_en = 1'b1;
    gap(3);

    // Frame before any vsync: nothing leaves either instance.
    line(8, 1'b0); line(8, 1'b0);
    vsync(1'b0);                      // first edge: frame check suppressed

    // Known colours through the zero-skip instance.
    line(8, 1'b1); line(8, 1'b0);
    vsync(1'b0);                      // skip-2 instance becomes valid

    // Last line ends in the same cycle vsync rises.
    line(8, 1'b0);
    send_line(8, 1'b0);
    end_line(1'b1, 8);
    vsync(1'b1);

    line(8, 1'b0); line(8, 1'b0);
    vsync(1'b0);

    // Odd-length line, good line, one-byte glitch: three lines in a frame.
    line(7, 1'b0); line(8, 1'b0); line(1, 1'b0);
    vsync(1'b0);

    // Reset in the middle of a line, then resume the same frame.
    line(8, 1'b0);
    send_line(6, 1'b0);
    do_reset(3);
    cmos_data = 8'($urandom_range(0, 255));
    send_line(4, 1'b0);
    end_line(1'b0, 5);
    gap(3);
    check_counts("resume");
    line(8, 1'b0);
    vsync(1'b0);

    line(8, 1'b0); line(8, 1'b0);
    vsync(1'b0);
    line(8, 1'b1); line(8, 1'b0);
    vsync(1'b0);

    gap(5);
    chk("final_pending_a", 32'(q_a.size()), 32'd0);
    chk("final_pending_b", 32'(q_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
